// File: rtl/pipe_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : pipe_exe_muldiv
// Brief    : EXE-stage iterative multiply/divide unit. Handles 32x32 signed
//            and unsigned multiply (Hi:Lo product) and divide (Lo=quotient,
//            Hi=remainder). It works one bit per cycle and holds the
//            upstream pipeline stalled until the result is ready.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_exe_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Upper half: running partial product / remainder.
  // Lower half: multiplier bits still to consume / quotient being built.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand (mult) or divisor (div), as a magnitude.
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d;

  // Operand signs count only for the signed ops (Op[0]==0).
  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_sh, w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_sa    = ~Op[0] & A[WIDTH-1];
  assign w_sb    = ~Op[0] & B[WIDTH-1];
  assign w_abs_a = w_sa ? -A : A;
  assign w_abs_b = w_sb ? -B : B;

  // Shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opr_q} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division step. The remainder always stays below the divisor,
  // so the shifted value fits in WIDTH+1 bits.
  assign w_div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, opr_q};
  assign w_div_next = w_div_diff[WIDTH]
                    ? {w_div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign fix-up sources.
  assign w_prod_neg = -acc_q;
  assign w_quo      = acc_q[WIDTH-1:0];
  assign w_rem      = acc_q[2*WIDTH-1:WIDTH];

  // Next-state and datapath update. Flush outranks everything except reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            dz_d = 1'b0;
            if (Op[1] && (B == '0)) begin
              state_d = S_DONE;
              hi_d    = A;
              lo_d    = '1;
              dz_d    = 1'b1;
            end else begin
              state_d  = S_BUSY;
              cnt_d    = '0;
              is_div_d = Op[1];
              sa_d     = w_sa;
              sb_d     = w_sb;
              opr_d    = Op[1] ? w_abs_b : w_abs_a;
              acc_d    = {{WIDTH{1'b0}}, (Op[1] ? w_abs_a : w_abs_b)};
            end
          end
        end
        S_BUSY: begin
          acc_d = is_div_q ? w_div_next : w_mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          state_d = S_DONE;
          if (is_div_q) begin
            lo_d = (sa_q ^ sb_q) ? -w_quo : w_quo;
            hi_d = sa_q ? -w_rem : w_rem;
          end else if (sa_q ^ sb_q) begin
            {hi_d, lo_d} = w_prod_neg;
          end else begin
            {hi_d, lo_d} = acc_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
    end
  end

  // Stall covers the op from its first EXE cycle until the result cycle;
  // a flush releases the pipeline in the same cycle.
  assign Stall   = ~Flush & (((state_q == S_IDLE) & Start)
                             | (state_q == S_BUSY) | (state_q == S_FIX));
  assign Busy    = (state_q != S_IDLE);
  assign Done    = (state_q == S_DONE);
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_exe_muldiv
// Brief    : Self-checking bench for pipe_exe_muldiv: directed vector table,
//            flush and mid-op reset sequences, randomized ops vs. model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_exe_muldiv;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Clrn, Start, Flush;
  logic [1:0]   Op;
  logic [W-1:0] A, B;
  logic         Stall, Busy, Done, DivZero;
  logic [W-1:0] Hi, Lo;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] last_hi, last_lo;

  always #5 Clk = ~Clk;

  pipe_exe_muldiv #(.WIDTH(W)) dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions (64-bit integer math).
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (op)
      2'b00: begin p = sa * sb; {hi, lo} = p; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endtask

  // Issue one op at the start of a cycle (called at posedge+1) and check it.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz);
    int   cyc, exp_lat;
    logic st_ok;
    exp_lat = (op[1] && b == 32'd0) ? 1 : W + 2;
    Start = 1'b1; Op = op; A = a; B = b;
    cyc = 0; st_ok = 1'b1;
    @(negedge Clk);
    while (Done !== 1'b1 && cyc < 120) begin
      if (Stall !== 1'b1) st_ok = 1'b0;
      @(posedge Clk); #1;
      cyc++;
      @(negedge Clk);
    end
    chk({nm, ":stall_hold"}, 64'(st_ok), 64'd1);
    chk({nm, ":latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, ":stall_done"}, 64'(Stall), 64'd0);
    chk({nm, ":hi"}, 64'(Hi), 64'(ehi));
    chk({nm, ":lo"}, 64'(Lo), 64'(elo));
    chk({nm, ":divzero"}, 64'(DivZero), 64'(edz));
    last_hi = ehi; last_lo = elo;
    Start = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk({nm, ":idle_after"}, {62'd0, Busy, Done}, 64'd0);
    chk({nm, ":dz_sticky"}, 64'(DivZero), 64'(edz));
    @(posedge Clk); #1;
  endtask

  initial begin
    logic [31:0] mh, ml, ra, rb;
    logic        md, seen;
    logic [1:0]  rop;

    vecs[0]  = '{2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[4]  = '{2'b10, 32'h0000_1234,  32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'b01, 32'd3,          32'd5,         32'd0,         32'd15,        1'b0};
    vecs[6]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
    vecs[11] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};

    Clrn = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 2'b00; A = '0; B = '0;
    last_hi = '0; last_lo = '0;
    @(negedge Clk);
    chk("reset:flags", {60'd0, Stall, Busy, Done, DivZero}, 64'd0);
    chk("reset:hilo", {Hi, Lo}, 64'd0);
    @(posedge Clk); #1;
    Clrn = 1'b1;
    @(posedge Clk); #1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // Flush a multu in cycle 10: stall drops at once, no Done, Hi/Lo kept.
    Start = 1'b1; Op = 2'b01; A = 32'd1234; B = 32'd5678;
    repeat (10) begin @(posedge Clk); #1; end
    Flush = 1'b1;
    @(negedge Clk);
    chk("flush:stall_low", 64'(Stall), 64'd0);
    chk("flush:busy_before", 64'(Busy), 64'd1);
    @(posedge Clk); #1;
    Flush = 1'b0; Start = 1'b0;
    @(negedge Clk);
    chk("flush:idle", {62'd0, Busy, Done}, 64'd0);
    chk("flush:hilo_kept", {Hi, Lo}, {last_hi, last_lo});
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done === 1'b1) seen = 1'b1;
    end
    chk("flush:no_done", 64'(seen), 64'd0);
    @(posedge Clk); #1;

    // Asynchronous reset in cycle 20 of a div, then a clean op.
    Start = 1'b1; Op = 2'b10; A = 32'h7654_3210; B = 32'd3;
    repeat (20) begin @(posedge Clk); #1; end
    Clrn = 1'b0; Start = 1'b0;
    #1;
    chk("rst_mid:flags", {60'd0, Stall, Busy, Done, DivZero}, 64'd0);
    chk("rst_mid:hilo", {Hi, Lo}, 64'd0);
    @(posedge Clk); #1;
    Clrn = 1'b1;
    @(posedge Clk); #1;
    run_op("after_rst", 2'b11, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      model(rop, ra, rb, mh, ml, md);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, mh, ml, md);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
